// File: rtl/lc4_exec_pkg.sv
// Shared types and constants for the registered multi-lane LC4 execute stage.
package lc4_exec_pkg;

   localparam int FIFO_DEPTH = 2;
   localparam logic [15:0] PC_INC = 16'h0001;

   // Widest ROB tag a slot result can carry; the top TAG_W must not exceed it.
   localparam int MAX_TAG_W = 5;

   typedef struct packed {
      logic [15:0]          exec;
      logic                 is_load;
      logic [2:0]           rd;
      logic                 we;
      logic [MAX_TAG_W-1:0] tag;
      logic                 valid;
   } slot_res_t;

endpackage

// File: rtl/lc4_alu.sv
// LC4 ALU: arithmetic, logic, shifts, compares, address and branch-target generation.
module lc4_alu
   import lc4_exec_pkg::*;
(
   input  logic [15:0] insn,
   input  logic [15:0] pc,
   input  logic [15:0] r1data,
   input  logic [15:0] r2data,
   output logic [15:0] result
);

   logic [15:0] sext5, sext6, sext7, uimm7, sext9, sext11, cmp_b;
   logic        cmp_lt, cmp_eq;

   assign sext5  = {{11{insn[4]}}, insn[4:0]};
   assign sext6  = {{10{insn[5]}}, insn[5:0]};
   assign sext7  = {{9{insn[6]}}, insn[6:0]};
   assign uimm7  = {9'd0, insn[6:0]};
   assign sext9  = {{7{insn[8]}}, insn[8:0]};
   assign sext11 = {{5{insn[10]}}, insn[10:0]};

   always_comb begin
      cmp_b  = r2data;
      cmp_lt = 1'b0;
      case (insn[8:7])
         2'b00: cmp_lt = $signed(r1data) < $signed(r2data);
         2'b01: cmp_lt = r1data < r2data;
         2'b10: begin
            cmp_b  = sext7;
            cmp_lt = $signed(r1data) < $signed(sext7);
         end
         default: begin
            cmp_b  = uimm7;
            cmp_lt = r1data < uimm7;
         end
      endcase
      cmp_eq = (r1data == cmp_b);
   end

   always_comb begin
      result = 16'h0000;
      case (insn[15:12])
         4'b0000: result = pc + PC_INC + sext9;
         4'b0001: begin
            case (insn[5:3])
               3'b000:  result = r1data + r2data;
               3'b001:  result = r1data * r2data;
               3'b010:  result = r1data - r2data;
               3'b011:  result = (r2data == 16'd0) ? 16'd0 : r1data / r2data;
               default: result = r1data + sext5;
            endcase
         end
         4'b0010: result = cmp_lt ? 16'hFFFF : (cmp_eq ? 16'h0000 : 16'h0001);
         4'b0100: result = insn[11] ? {pc[15], insn[10:0], 4'b0000} : r1data;
         4'b0101: begin
            case (insn[5:3])
               3'b000:  result = r1data & r2data;
               3'b001:  result = ~r1data;
               3'b010:  result = r1data | r2data;
               3'b011:  result = r1data ^ r2data;
               default: result = r1data & sext5;
            endcase
         end
         4'b0110, 4'b0111: result = r1data + sext6;
         4'b1000: result = r1data;
         4'b1001: result = sext9;
         4'b1010: begin
            case (insn[5:4])
               2'b00:   result = r1data << insn[3:0];
               2'b01:   result = 16'($signed(r1data) >>> insn[3:0]);
               2'b10:   result = r1data >> insn[3:0];
               default: result = (r2data == 16'd0) ? 16'd0 : r1data % r2data;
            endcase
         end
         4'b1100: result = insn[11] ? (pc + PC_INC + sext11) : r1data;
         4'b1101: result = {insn[7:0], r1data[7:0]};
         4'b1111: result = {8'h80, insn[7:0]};
         default: result = 16'h0000;
      endcase
   end

endmodule

// File: rtl/lc4_decoder.sv
// LC4 writeback decode: destination register, write enable, load flag, pc+1 select.
module lc4_decoder (
   input  logic [6:0] insn_hi,
   output logic [2:0] wsel,
   output logic       regfile_we,
   output logic       is_load,
   output logic       select_pc_plus_one
);

   logic [3:0] opcode;
   assign opcode = insn_hi[6:3];

   always_comb begin
      wsel               = insn_hi[2:0];
      regfile_we         = 1'b0;
      is_load            = 1'b0;
      select_pc_plus_one = 1'b0;
      case (opcode)
         4'b0001, 4'b0101, 4'b1001, 4'b1010, 4'b1101: regfile_we = 1'b1;
         4'b0110: begin
            regfile_we = 1'b1;
            is_load    = 1'b1;
         end
         // JSR/JSRR and TRAP link the return address into R7
         4'b0100, 4'b1111: begin
            regfile_we         = 1'b1;
            wsel               = 3'd7;
            select_pc_plus_one = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lc4_exec_lane.sv
// One execute slot: decode, ALU and the pc+1 link mux; empty slots produce an all-zero result.
module lc4_exec_lane
   import lc4_exec_pkg::*;
#(
   parameter int TAG_W = 5
) (
   input  logic             slot_valid,
   input  logic [15:0]      insn,
   input  logic [15:0]      pc,
   input  logic [15:0]      r1data,
   input  logic [15:0]      r2data,
   input  logic [TAG_W-1:0] tag,
   output slot_res_t        res
);

   logic [2:0]  wsel;
   logic        regfile_we, is_load, select_pc_plus_one;
   logic [15:0] alu_result, pc_plus_one;

   lc4_decoder u_dec (
      .insn_hi            (insn[15:9]),
      .wsel               (wsel),
      .regfile_we         (regfile_we),
      .is_load            (is_load),
      .select_pc_plus_one (select_pc_plus_one)
   );

   lc4_alu u_alu (
      .insn   (insn),
      .pc     (pc),
      .r1data (r1data),
      .r2data (r2data),
      .result (alu_result)
   );

   assign pc_plus_one = pc + PC_INC;

   always_comb begin
      res = '0;
      if (slot_valid) begin
         res.exec    = select_pc_plus_one ? pc_plus_one : alu_result;
         res.is_load = is_load;
         res.rd      = wsel;
         res.we      = regfile_we;
         res.tag     = MAX_TAG_W'(tag);
         res.valid   = 1'b1;
      end
   end

endmodule

// File: rtl/lc4_exec_stage_pipe.sv
// Registered multi-lane LC4 execute stage with a 2-entry group skid FIFO and flush.
// Optional build macro LC4_EXEC_STATS_EN adds stat_groups / stat_stalls counters.
module lc4_exec_stage_pipe
   import lc4_exec_pkg::*;
#(
   parameter int LANES = 2,
   parameter int TAG_W = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES-1:0]       in_slot_valid,
   input  logic [16*LANES-1:0]    in_insn,
   input  logic [16*LANES-1:0]    in_pc,
   input  logic [16*LANES-1:0]    in_r1data,
   input  logic [16*LANES-1:0]    in_r2data,
   input  logic [TAG_W*LANES-1:0] in_tag,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES-1:0]       out_slot_valid,
   output logic [16*LANES-1:0]    out_exec,
   output logic [LANES-1:0]       out_is_load,
   output logic [3*LANES-1:0]     out_rd,
   output logic [LANES-1:0]       out_we,
   output logic [TAG_W*LANES-1:0] out_tag
`ifdef LC4_EXEC_STATS_EN
   ,
   output logic [31:0]            stat_groups,
   output logic [31:0]            stat_stalls
`endif
);

   slot_res_t [LANES-1:0] lane_res;
   slot_res_t [LANES-1:0] head_q, tail_q;
   logic [1:0]            count_q;
   logic                  push, pop;

   for (genvar s = 0; s < LANES; s++) begin : g_lane
      lc4_exec_lane #(.TAG_W(TAG_W)) u_lane (
         .slot_valid (in_slot_valid[s]),
         .insn       (in_insn[16*s +: 16]),
         .pc         (in_pc[16*s +: 16]),
         .r1data     (in_r1data[16*s +: 16]),
         .r2data     (in_r2data[16*s +: 16]),
         .tag        (in_tag[TAG_W*s +: TAG_W]),
         .res        (lane_res[s])
      );
   end

   assign in_ready  = (count_q < 2'(FIFO_DEPTH));
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   // head_q is always the oldest group; tail_q only matters at count 2
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 2'd0;
         head_q  <= '0;
         tail_q  <= '0;
      end else if (flush) begin
         count_q <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count_q == 2'd0) head_q <= lane_res;
               else                 tail_q <= lane_res;
               count_q <= count_q + 2'd1;
            end
            2'b01: begin
               head_q  <= tail_q;
               count_q <= count_q - 2'd1;
            end
            2'b11: head_q <= lane_res;
            default: ;
         endcase
      end
   end

   always_comb begin
      for (int s = 0; s < LANES; s++) begin
         out_slot_valid[s]        = head_q[s].valid;
         out_exec[16*s +: 16]     = head_q[s].exec;
         out_is_load[s]           = head_q[s].is_load;
         out_rd[3*s +: 3]         = head_q[s].rd;
         out_we[s]                = head_q[s].we;
         out_tag[TAG_W*s +: TAG_W] = TAG_W'(head_q[s].tag);
      end
   end

`ifdef LC4_EXEC_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_groups <= 32'd0;
         stat_stalls <= 32'd0;
      end else begin
         if (push)                 stat_groups <= stat_groups + 32'd1;
         if (in_valid && !in_ready) stat_stalls <= stat_stalls + 32'd1;
      end
   end
`endif

endmodule
